// File: rtl/calc_key_sequencer.sv
// Keypad sequencer for the 4-bit calculator: collects two operands from remote key
// events, drives the external adder, latches the sum and feeds the display.
module calc_key_sequencer #(
    parameter int TIMEOUT = 500000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic [3:0] add_sum,
    input  logic       add_cout,
    output logic [3:0] add_a,
    output logic [3:0] add_b,
    output logic [3:0] display,
    output logic       overflow,
    output logic [2:0] state,
    output logic       key_drop
);
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_OP1      = 3'd1,
        S_OP2_WAIT = 3'd2,
        S_OP2      = 3'd3,
        S_CALC     = 3'd4,
        S_RESULT   = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    op_a_q, op_a_d;
    logic [3:0]    op_b_q, op_b_d;
    logic [3:0]    disp_q, disp_d;
    logic [3:0]    result_q, result_d;
    logic          ovf_q, ovf_d;
    logic          drop_q, drop_d;
    logic [CW-1:0] tmo_q, tmo_d;

    logic is_digit, is_add, is_eq, is_clr, tmo_hit, do_clear;

    always_comb begin
        is_digit = key_valid && (key_code <= 4'd9);
        is_add   = key_valid && (key_code == 4'd10);
        is_eq    = key_valid && (key_code == 4'd11);
        is_clr   = key_valid && (key_code == 4'd12);
        tmo_hit  = !key_valid && (state_q != S_IDLE) && (tmo_q == TMO_LAST);
        // A CLEAR key in CALC is just another discarded key.
        do_clear = (is_clr && (state_q != S_CALC)) || tmo_hit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_a_q   <= '0;
            op_b_q   <= '0;
            disp_q   <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            drop_q   <= 1'b0;
            tmo_q    <= '0;
        end else begin
            state_q  <= state_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            disp_q   <= disp_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            drop_q   <= drop_d;
            tmo_q    <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (do_clear) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:     if (is_digit) state_d = S_OP1;
                S_OP1:      if (is_add) state_d = S_OP2_WAIT;
                S_OP2_WAIT: if (is_digit) state_d = S_OP2;
                S_OP2:      if (is_eq) state_d = S_CALC;
                S_CALC:     state_d = S_RESULT;
                S_RESULT: begin
                    if (is_digit)
                        state_d = S_OP1;
                    else if (is_add && !ovf_q)
                        state_d = S_OP2_WAIT;
                end
                default:    state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        disp_d   = disp_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        drop_d   = 1'b0;
        tmo_d    = (key_valid || (state_q == S_IDLE)) ? '0 : tmo_q + CW'(1);
        if (do_clear) begin
            op_a_d   = '0;
            op_b_d   = '0;
            disp_d   = '0;
            result_d = '0;
            ovf_d    = 1'b0;
            tmo_d    = '0;
        end else begin
            case (state_q)
                S_IDLE, S_OP1: begin
                    if (is_digit) begin
                        op_a_d = key_code;
                        disp_d = key_code;
                    end
                end
                S_OP2_WAIT, S_OP2: begin
                    if (is_digit) begin
                        op_b_d = key_code;
                        disp_d = key_code;
                    end
                end
                S_CALC: begin
                    result_d = add_sum;
                    ovf_d    = add_cout;
                    disp_d   = add_sum;
                    drop_d   = key_valid;
                end
                S_RESULT: begin
                    if (is_digit) begin
                        op_a_d = key_code;
                        op_b_d = '0;
                        ovf_d  = 1'b0;
                        disp_d = key_code;
                    end else if (is_add && !ovf_q) begin
                        // Chained add: the previous result becomes operand A.
                        op_a_d = result_q;
                        op_b_d = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign add_a    = op_a_q;
    assign add_b    = op_b_q;
    assign display  = disp_q;
    assign overflow = ovf_q;
    assign state    = state_q;
    assign key_drop = drop_q;
endmodule
